csi_lane_state_monitor: RTL and testbench

- Parametrised successor to the passive CSI bidir pin interface. Samples the LP-level (single-ended) state of the CSI clock lane and of LANE_N data lanes on the system clock.
- Tracks each lane through the D-PHY LP/HS/escape protocol with a per-lane state machine.
- Reports SoT, EoT and protocol errors, and keeps per-lane statistics counters.
- Sits beside the pin interface in the checker environment and feeds scoreboards and coverage.

---
 rtl/csi_lane_state_monitor.sv | 237 +++++++++++++++++++++++
 tb/tb_csi_lane_state_monitor.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/csi_lane_state_monitor.sv
// CSI D-PHY lane state monitor: samples and filters the LP pairs of the clock
// lane and LANE_N data lanes, and tracks each lane through LP/HS/escape states.
module csi_lane_state_monitor #(
  parameter int LANE_N   = 4,
  parameter int FILT_LEN = 2,
  parameter int PRPR_MIN = 3,
  parameter int CNT_W    = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANE_N-1:0]            lp_dp,
  input  logic [LANE_N-1:0]            lp_dn,
  input  logic                         lp_clk_p,
  input  logic                         lp_clk_n,
  input  logic [LANE_N-1:0]            lane_en,
  input  logic                         cnt_clear,
  output logic [3*(LANE_N+1)-1:0]      lane_state,
  output logic [LANE_N-1:0]            sot_pulse,
  output logic [LANE_N-1:0]            eot_pulse,
  output logic [LANE_N:0]              err_pulse,
  output logic [2*(LANE_N+1)-1:0]      err_code,
  output logic                         clk_hs,
  output logic                         all_stop,
  output logic [LANE_N*CNT_W-1:0]      sot_cnt,
  output logic [LANE_N*CNT_W-1:0]      err_cnt
);

  localparam int L = LANE_N + 1;

  typedef enum logic [2:0] {
    ST_STOP     = 3'd0,
    ST_HS_RQST  = 3'd1,
    ST_HS_PRPR  = 3'd2,
    ST_HS       = 3'd3,
    ST_ESC_RQST = 3'd4,
    ST_ESC      = 3'd5,
    ST_ERR      = 3'd7
  } state_t;

  // Index 0 is the clock lane, index i+1 is data lane i.
  logic [L-1:0] w_p, w_n, w_en;
  assign w_p  = {lp_dp, lp_clk_p};
  assign w_n  = {lp_dn, lp_clk_n};
  assign w_en = {lane_en, 1'b1};

  logic [1:0] r_s1   [L];
  logic [1:0] r_s2   [L];
  logic [1:0] r_prev [L];
  logic [1:0] r_filt [L];
  logic [3:0] r_run  [L];
  logic [3:0] w_run  [L];

  state_t     r_st    [L];
  state_t     w_nst   [L];
  logic [7:0] r_prep  [L];
  logic [7:0] w_nprep [L];
  logic [1:0] r_code  [L];
  logic [1:0] w_ncode [L];

  logic [L-1:0]      w_err, r_err;
  logic [LANE_N-1:0] w_sot, w_eot, r_sot, r_eot;
  logic              w_all_stop, r_clk_hs, r_all_stop;

  logic [CNT_W-1:0] r_sc [LANE_N];
  logic [CNT_W-1:0] r_ec [LANE_N];

  always_comb begin
    for (int l = 0; l < L; l++) begin
      w_run[l] = 4'd1;
      if (r_s2[l] == r_prev[l])
        w_run[l] = (r_run[l] == 4'hF) ? 4'hF : r_run[l] + 4'd1;
    end
  end

  // Run length saturates, so reset value 15 means "11 already settled".
  always_ff @(posedge clk) begin
    for (int l = 0; l < L; l++) begin
      if (rst) begin
        r_s1[l]   <= 2'b11;
        r_s2[l]   <= 2'b11;
        r_prev[l] <= 2'b11;
        r_filt[l] <= 2'b11;
        r_run[l]  <= 4'hF;
      end else begin
        r_s1[l]   <= {w_p[l], w_n[l]};
        r_s2[l]   <= r_s1[l];
        r_prev[l] <= r_s2[l];
        r_run[l]  <= w_run[l];
        if (w_run[l] >= 4'(FILT_LEN))
          r_filt[l] <= r_s2[l];
      end
    end
  end

  always_comb begin
    w_err = '0;
    for (int l = 0; l < L; l++) begin
      w_nst[l]   = r_st[l];
      w_nprep[l] = r_prep[l];
      w_ncode[l] = r_code[l];
      unique case (r_st[l])
        ST_STOP: begin
          if (r_filt[l] == 2'b01) begin
            w_nst[l] = ST_HS_RQST;
          end else if (r_filt[l] == 2'b10 && l != 0) begin
            w_nst[l] = ST_ESC_RQST;
          end else if (r_filt[l] != 2'b11) begin
            w_nst[l]   = ST_ERR;
            w_err[l]   = 1'b1;
            w_ncode[l] = 2'd1;
          end
        end
        ST_HS_RQST: begin
          if (r_filt[l] == 2'b00) begin
            w_nst[l]   = ST_HS_PRPR;
            w_nprep[l] = 8'd1;
          end else if (r_filt[l] != 2'b01) begin
            w_nst[l]   = (r_filt[l] == 2'b11) ? ST_STOP : ST_ERR;
            w_err[l]   = 1'b1;
            w_ncode[l] = 2'd3;
          end
        end
        ST_HS_PRPR: begin
          if (r_filt[l] != 2'b00) begin
            w_nst[l]   = ST_ERR;
            w_err[l]   = 1'b1;
            w_ncode[l] = 2'd2;
          end else if (r_prep[l] >= 8'(PRPR_MIN)) begin
            w_nst[l] = ST_HS;
          end else if (r_prep[l] != 8'hFF) begin
            w_nprep[l] = r_prep[l] + 8'd1;
          end
        end
        ST_HS: begin
          if (r_filt[l] == 2'b11) begin
            w_nst[l] = ST_STOP;
          end else if (r_filt[l] != 2'b00) begin
            w_nst[l]   = ST_ERR;
            w_err[l]   = 1'b1;
            w_ncode[l] = 2'd3;
          end
        end
        ST_ESC_RQST: begin
          if (r_filt[l] == 2'b00) begin
            w_nst[l] = ST_ESC;
          end else if (r_filt[l] == 2'b11) begin
            w_nst[l] = ST_STOP;
          end else if (r_filt[l] == 2'b01) begin
            w_nst[l]   = ST_ERR;
            w_err[l]   = 1'b1;
            w_ncode[l] = 2'd3;
          end
        end
        ST_ESC, ST_ERR: begin
          if (r_filt[l] == 2'b11) w_nst[l] = ST_STOP;
        end
        default: w_nst[l] = ST_STOP;
      endcase
      if (!w_en[l]) begin
        w_nst[l]   = ST_STOP;
        w_nprep[l] = 8'd0;
        w_err[l]   = 1'b0;
        w_ncode[l] = r_code[l];
      end
    end
  end

  // SoT/EoT are the only paths PRPR->HS and HS->STOP while enabled.
  always_comb begin
    w_all_stop = (w_nst[0] == ST_STOP);
    for (int i = 0; i < LANE_N; i++) begin
      w_sot[i] = lane_en[i] && r_st[i+1] == ST_HS_PRPR && w_nst[i+1] == ST_HS;
      w_eot[i] = lane_en[i] && r_st[i+1] == ST_HS && w_nst[i+1] == ST_STOP;
      if (lane_en[i] && w_nst[i+1] != ST_STOP) w_all_stop = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int l = 0; l < L; l++) begin
        r_st[l]   <= ST_STOP;
        r_prep[l] <= 8'd0;
        r_code[l] <= 2'd0;
      end
      r_err      <= '0;
      r_sot      <= '0;
      r_eot      <= '0;
      r_clk_hs   <= 1'b0;
      r_all_stop <= 1'b1;
    end else begin
      for (int l = 0; l < L; l++) begin
        r_st[l]   <= w_nst[l];
        r_prep[l] <= w_nprep[l];
        r_code[l] <= w_ncode[l];
      end
      r_err      <= w_err;
      r_sot      <= w_sot;
      r_eot      <= w_eot;
      r_clk_hs   <= (w_nst[0] == ST_HS);
      r_all_stop <= w_all_stop;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANE_N; i++) begin
      if (rst || cnt_clear) begin
        r_sc[i] <= '0;
        r_ec[i] <= '0;
      end else if (lane_en[i]) begin
        if (r_sot[i] && r_sc[i] != '1) r_sc[i] <= r_sc[i] + 1'b1;
        if (r_err[i+1] && r_ec[i] != '1) r_ec[i] <= r_ec[i] + 1'b1;
      end
    end
  end

  always_comb begin
    lane_state = '0;
    err_code   = '0;
    sot_cnt    = '0;
    err_cnt    = '0;
    for (int l = 0; l < L; l++) begin
      lane_state[3*l +: 3] = r_st[l];
      err_code[2*l +: 2]   = r_code[l];
    end
    for (int i = 0; i < LANE_N; i++) begin
      sot_cnt[CNT_W*i +: CNT_W] = r_sc[i];
      err_cnt[CNT_W*i +: CNT_W] = r_ec[i];
    end
  end

  assign sot_pulse = r_sot;
  assign eot_pulse = r_eot;
  assign err_pulse = r_err;
  assign clk_hs    = r_clk_hs;
  assign all_stop  = r_all_stop;

endmodule

// File: tb/tb_csi_lane_state_monitor.sv
// Scoreboard bench for csi_lane_state_monitor: a history-based reference
// model predicts every registered output, a monitor pops and compares.
module tb_csi_lane_state_monitor;

  localparam int N    = 4;
  localparam int FL   = 2;
  localparam int PM   = 3;
  localparam int CW   = 4;
  localparam int MAXC = (1 << CW) - 1;

  logic              clk = 1'b0;
  logic              rst, cnt_clear, lp_clk_p, lp_clk_n;
  logic [N-1:0]      lp_dp, lp_dn, lane_en;
  logic [3*(N+1)-1:0] lane_state;
  logic [N-1:0]      sot_pulse, eot_pulse;
  logic [N:0]        err_pulse;
  logic [2*(N+1)-1:0] err_code;
  logic              clk_hs, all_stop;
  logic [N*CW-1:0]   sot_cnt, err_cnt;

  csi_lane_state_monitor #(
    .LANE_N(N), .FILT_LEN(FL), .PRPR_MIN(PM), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .lp_dp(lp_dp), .lp_dn(lp_dn),
    .lp_clk_p(lp_clk_p), .lp_clk_n(lp_clk_n), .lane_en(lane_en),
    .cnt_clear(cnt_clear), .lane_state(lane_state),
    .sot_pulse(sot_pulse), .eot_pulse(eot_pulse),
    .err_pulse(err_pulse), .err_code(err_code), .clk_hs(clk_hs),
    .all_stop(all_stop), .sot_cnt(sot_cnt), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3*(N+1)-1:0] st;
    logic [N-1:0]       sot;
    logic [N-1:0]       eot;
    logic [N:0]         err;
    logic [2*(N+1)-1:0] code;
    logic               hs;
    logic               alls;
    logic [N*CW-1:0]    sc;
    logic [N*CW-1:0]    ec;
  } exp_t;

  typedef struct packed {
    logic [N:0] p;
    logic [N:0] n;
  } raw_t;

  exp_t sbq[$];
  raw_t hist[$];
  int   lastrst = -1;
  int   n_run = 0;
  int   n_fail = 0;

  int         m_st[N+1];
  int         m_prep[N+1];
  logic [1:0] m_code[N+1];
  logic [1:0] m_filt[N+1];
  bit         m_err[N+1];
  bit         m_sot[N];
  bit         m_eot[N];
  int         m_sc[N];
  int         m_ec[N];
  bit         m_hs, m_alls;

  logic [1:0] d_pair[N+1];
  logic [N-1:0] d_en;
  logic d_rst, d_clr;

  function automatic void chk(string nm, logic [63:0] a, logic [63:0] x);
    n_run++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, x);
    end
  endfunction

  function automatic logic [1:0] raw_at(int j, int l);
    if (j < 0 || j <= lastrst) return 2'b11;
    return {hist[j].p[l], hist[j].n[l]};
  endfunction

  function automatic void err_to(int l, int code, int ns);
    m_st[l]   = ns;
    m_err[l]  = 1'b1;
    m_code[l] = 2'(code);
  endfunction

  function automatic void lane_step(int l, bit en);
    logic [1:0] pr;
    pr = m_filt[l];
    m_err[l] = 1'b0;
    if (l > 0) begin
      m_sot[l-1] = 1'b0;
      m_eot[l-1] = 1'b0;
    end
    if (!en) begin
      m_st[l]   = 0;
      m_prep[l] = 0;
      return;
    end
    case (m_st[l])
      0: if (pr == 2'b01) m_st[l] = 1;
         else if (pr == 2'b10 && l > 0) m_st[l] = 4;
         else if (pr != 2'b11) err_to(l, 1, 7);
      1: if (pr == 2'b00) begin m_st[l] = 2; m_prep[l] = 1; end
         else if (pr == 2'b11) err_to(l, 3, 0);
         else if (pr == 2'b10) err_to(l, 3, 7);
      2: if (pr != 2'b00) err_to(l, 2, 7);
         else if (m_prep[l] == PM) begin
           m_st[l] = 3;
           if (l > 0) m_sot[l-1] = 1'b1;
         end else m_prep[l] = (m_prep[l] < 255) ? m_prep[l] + 1 : 255;
      3: if (pr == 2'b11) begin
           m_st[l] = 0;
           if (l > 0) m_eot[l-1] = 1'b1;
         end else if (pr != 2'b00) err_to(l, 3, 7);
      4: if (pr == 2'b00) m_st[l] = 5;
         else if (pr == 2'b11) m_st[l] = 0;
         else if (pr == 2'b01) err_to(l, 3, 7);
      default: if (pr == 2'b11) m_st[l] = 0;
    endcase
  endfunction

  function automatic void model_edge();
    raw_t r;
    exp_t e;
    int k;
    bit eq;
    logic [1:0] pr;
    r.p = {lp_dp, lp_clk_p};
    r.n = {lp_dn, lp_clk_n};
    k = hist.size();
    hist.push_back(r);
    if (rst) begin
      lastrst = k;
      for (int l = 0; l <= N; l++) begin
        m_st[l] = 0; m_prep[l] = 0; m_code[l] = 2'd0;
        m_filt[l] = 2'b11; m_err[l] = 1'b0;
      end
      for (int i = 0; i < N; i++) begin
        m_sot[i] = 1'b0; m_eot[i] = 1'b0; m_sc[i] = 0; m_ec[i] = 0;
      end
      m_hs = 1'b0;
      m_alls = 1'b1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (cnt_clear) begin
          m_sc[i] = 0;
          m_ec[i] = 0;
        end else if (lane_en[i]) begin
          if (m_sot[i] && m_sc[i] < MAXC) m_sc[i]++;
          if (m_err[i+1] && m_ec[i] < MAXC) m_ec[i]++;
        end
      end
      lane_step(0, 1'b1);
      for (int i = 0; i < N; i++) lane_step(i + 1, lane_en[i]);
      // filtered pair = last FL synchronised samples when they all agree
      for (int l = 0; l <= N; l++) begin
        pr = raw_at(k - 2, l);
        eq = 1'b1;
        for (int d = 1; d < FL; d++)
          if (raw_at(k - 2 - d, l) != pr) eq = 1'b0;
        if (eq) m_filt[l] = pr;
      end
      m_hs = (m_st[0] == 3);
      m_alls = (m_st[0] == 0);
      for (int i = 0; i < N; i++)
        if (lane_en[i] && m_st[i+1] != 0) m_alls = 1'b0;
    end
    e = '0;
    for (int l = 0; l <= N; l++) begin
      e.st[3*l +: 3]  = 3'(m_st[l]);
      e.code[2*l +: 2] = m_code[l];
      e.err[l] = m_err[l];
    end
    for (int i = 0; i < N; i++) begin
      e.sot[i] = m_sot[i];
      e.eot[i] = m_eot[i];
      e.sc[CW*i +: CW] = CW'(m_sc[i]);
      e.ec[CW*i +: CW] = CW'(m_ec[i]);
    end
    e.hs = m_hs;
    e.alls = m_alls;
    sbq.push_back(e);
  endfunction

  task automatic tick();
    @(negedge clk);
    rst = d_rst;
    cnt_clear = d_clr;
    lane_en = d_en;
    lp_clk_p = d_pair[0][1];
    lp_clk_n = d_pair[0][0];
    for (int i = 0; i < N; i++) begin
      lp_dp[i] = d_pair[i+1][1];
      lp_dn[i] = d_pair[i+1][0];
    end
    model_edge();
  endtask

  task automatic run(int n);
    repeat (n) tick();
  endtask

  task automatic drive(int l, logic [1:0] pr, int n);
    d_pair[l] = pr;
    run(n);
  endtask

  task automatic burst(int l);
    drive(l, 2'b01, 4);
    drive(l, 2'b00, 6);
    drive(l, 2'b11, 6);
  endtask

  function automatic logic [1:0] succ(logic [1:0] pr, int l);
    case (pr)
      2'b11: return (l == 0 || $urandom_range(1) == 0) ? 2'b01 : 2'b10;
      2'b00: return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("lane_state", 64'(lane_state), 64'(e.st));
        chk("sot_pulse", 64'(sot_pulse), 64'(e.sot));
        chk("eot_pulse", 64'(eot_pulse), 64'(e.eot));
        chk("err_pulse", 64'(err_pulse), 64'(e.err));
        chk("err_code", 64'(err_code), 64'(e.code));
        chk("clk_hs", 64'(clk_hs), 64'(e.hs));
        chk("all_stop", 64'(all_stop), 64'(e.alls));
        chk("sot_cnt", 64'(sot_cnt), 64'(e.sc));
        chk("err_cnt", 64'(err_cnt), 64'(e.ec));
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    int hold[N+1];
    rst = 1'b1; cnt_clear = 1'b0; lane_en = '1;
    lp_clk_p = 1'b1; lp_clk_n = 1'b1; lp_dp = '1; lp_dn = '1;
    for (int l = 0; l <= N; l++) d_pair[l] = 2'b11;
    d_en = '1; d_rst = 1'b1; d_clr = 1'b0;
    run(3);
    d_rst = 1'b0;
    run(2);
    chk("reset_state", 64'(lane_state), 64'd0);
    chk("reset_allstop", 64'(all_stop), 64'd1);

    drive(1, 2'b01, 10);
    d_pair[1] = 2'b00;
    lat = -1;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (lat < 0 && sot_pulse[0]) lat = c;
    end
    chk("sot_latency", 64'(lat), 64'(FL + 6));
    drive(1, 2'b11, 10);
    chk("l0_sot_cnt", 64'(sot_cnt[CW-1:0]), 64'd1);

    drive(2, 2'b01, 10);
    drive(2, 2'b00, 2);
    drive(2, 2'b11, 10);
    chk("l1_err_cnt", 64'(err_cnt[2*CW-1:CW]), 64'd1);
    chk("l1_err_code", 64'(err_code[5:4]), 64'd2);

    drive(3, 2'b00, 1);
    drive(3, 2'b11, 10);
    chk("l2_glitch", 64'(lane_state[11:9]), 64'd0);

    drive(0, 2'b10, 5);
    drive(0, 2'b11, 10);
    chk("clk_err_code", 64'(err_code[1:0]), 64'd1);
    drive(0, 2'b01, 10);
    drive(0, 2'b00, 12);
    chk("clk_hs_on", 64'(clk_hs), 64'd1);
    chk("allstop_busy", 64'(all_stop), 64'd0);
    drive(0, 2'b11, 10);

    d_clr = 1'b1; tick(); d_clr = 1'b0;
    burst(4);
    drive(4, 2'b01, 4);
    d_pair[4] = 2'b00;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (m_sot[3]) break;
    end
    d_clr = 1'b1; tick(); d_clr = 1'b0;
    drive(4, 2'b00, 3);
    drive(4, 2'b11, 6);
    chk("l3_clear_wins", 64'(sot_cnt[4*CW-1:3*CW]), 64'd0);
    for (int b = 0; b < 20; b++) burst(4);
    chk("l3_saturate", 64'(sot_cnt[4*CW-1:3*CW]), 64'(MAXC));

    drive(1, 2'b01, 6);
    drive(1, 2'b00, 10);
    d_en[0] = 1'b0;
    run(3);
    chk("l0_disable", 64'(lane_state[5:3]), 64'd0);
    drive(1, 2'b11, 6);
    d_en[0] = 1'b1;
    run(6);

    drive(1, 2'b01, 6);
    drive(1, 2'b00, 10);
    d_rst = 1'b1; tick();
    d_rst = 1'b0; d_pair[1] = 2'b11; tick();
    chk("rst_counters", 64'({sot_cnt, err_cnt}), 64'd0);
    chk("rst_mid_hs", 64'(lane_state), 64'd0);
    run(8);

    for (int l = 0; l <= N; l++) hold[l] = 0;
    for (int cyc = 0; cyc < 2500; cyc++) begin
      for (int l = 0; l <= N; l++) begin
        if (hold[l] == 0) begin
          if ($urandom_range(3) != 0) d_pair[l] = succ(d_pair[l], l);
          else d_pair[l] = 2'($urandom_range(3));
          hold[l] = $urandom_range(8, 1);
        end
        hold[l]--;
      end
      d_clr = ($urandom_range(149) == 0);
      d_rst = ($urandom_range(699) == 0);
      if ($urandom_range(199) == 0) begin
        lat = $urandom_range(N - 1);
        d_en[lat] = ~d_en[lat];
      end
      tick();
    end

    d_rst = 1'b0; d_clr = 1'b0;
    run(5);
    @(posedge clk);
    #2;
    chk("queue_drained", 64'(sbq.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
